energy_accumulator: RTL and testbench

Downstream consumer of the energy monitor's spin-index step counter: accepts, per counter step, PARALLELISM signed partial-energy terms (one per spin lane), reduces them in a registered adder tree and accumulates them into a saturating total energy. It drives the counter's step/recount controls, uses the counter's maxed flag as the end-of-sweep marker, and presents the final energy to the comparator/host through a valid/ready handshake.

---
 rtl/energy_accumulator.sv | 144 ++++++++++++++
 tb/tb_energy_accumulator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_accumulator.sv
// Reduces PARALLELISM masked signed lane terms per beat and accumulates a saturating sweep energy.
// Latency: beat -> stage-1 register -> accumulator, result valid two cycles after the last beat.
// Backpressure: partial_ready_o is high throughout ACCUM; the result is held in OUT until energy_ready_i.
module energy_accumulator #(
  parameter int PARALLELISM   = 4,
  parameter int PARTIAL_WIDTH = 16,
  parameter int ENERGY_WIDTH  = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  input  logic                                 start_i,
  input  logic                                 partial_valid_i,
  output logic                                 partial_ready_o,
  input  logic [PARALLELISM*PARTIAL_WIDTH-1:0] partial_i,
  input  logic [PARALLELISM-1:0]               lane_mask_i,
  input  logic                                 last_i,
  output logic                                 step_en_o,
  output logic                                 recount_o,
  output logic [ENERGY_WIDTH-1:0]              energy_o,
  output logic                                 energy_valid_o,
  input  logic                                 energy_ready_i,
  output logic                                 overflow_o,
  output logic                                 busy_o
);

  localparam int SUM_WIDTH = PARTIAL_WIDTH + $clog2(PARALLELISM);
  localparam logic signed [ENERGY_WIDTH-1:0] E_MAX = {1'b0, {(ENERGY_WIDTH-1){1'b1}}};
  localparam logic signed [ENERGY_WIDTH-1:0] E_MIN = {1'b1, {(ENERGY_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                         state;
  logic                           beat_hs;
  logic                           out_hs;
  logic                           start_go;
  logic signed [SUM_WIDTH-1:0]    lane_sum;
  logic signed [ENERGY_WIDTH-1:0] s1_sum;
  logic                           s1_vld;
  logic signed [ENERGY_WIDTH-1:0] acc;
  logic signed [ENERGY_WIDTH:0]   acc_wide;
  logic signed [ENERGY_WIDTH-1:0] acc_next;
  logic                           acc_clamp;

  // Handshakes; en_i low masks every control strobe leaving the block.
  assign partial_ready_o = en_i && (state == ACCUM);
  assign beat_hs         = partial_valid_i && partial_ready_o;
  assign out_hs          = en_i && (state == OUT) && energy_ready_i;
  assign start_go        = en_i && start_i && ((state == IDLE) || out_hs);
  assign step_en_o       = beat_hs && !last_i;
  assign recount_o       = out_hs;
  assign energy_o        = acc;

  // Lane reduction: masked lanes contribute zero, others are sign-extended before adding.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < PARALLELISM; k++) begin
      if (lane_mask_i[k]) begin
        lane_sum = lane_sum + SUM_WIDTH'($signed(partial_i[k*PARTIAL_WIDTH +: PARTIAL_WIDTH]));
      end
    end
  end

  // Saturating add: one guard bit detects overflow, the guard's sign picks the clamp direction.
  always_comb begin
    acc_wide  = (ENERGY_WIDTH+1)'(acc) + (ENERGY_WIDTH+1)'(s1_sum);
    acc_clamp = acc_wide[ENERGY_WIDTH] != acc_wide[ENERGY_WIDTH-1];
    acc_next  = acc_wide[ENERGY_WIDTH-1:0];
    if (acc_clamp) begin
      acc_next = acc_wide[ENERGY_WIDTH] ? E_MIN : E_MAX;
    end
  end

  // Sweep control FSM with registered valid/busy outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      energy_valid_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (en_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= ACCUM;
            busy_o <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat_hs && last_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state          <= OUT;
          energy_valid_o <= 1'b1;
        end
        OUT: begin
          if (energy_ready_i) begin
            energy_valid_o <= 1'b0;
            if (start_i) begin
              state  <= ACCUM;
              busy_o <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state          <= IDLE;
          energy_valid_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage datapath: stage-1 lane sum register, stage-2 saturating accumulator with sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld     <= 1'b0;
      s1_sum     <= '0;
      acc        <= '0;
      overflow_o <= 1'b0;
    end else if (en_i) begin
      if (start_go) begin
        s1_vld     <= 1'b0;
        s1_sum     <= '0;
        acc        <= '0;
        overflow_o <= 1'b0;
      end else begin
        s1_vld <= beat_hs;
        s1_sum <= beat_hs ? ENERGY_WIDTH'(lane_sum) : '0;
        if (s1_vld) begin
          acc <= acc_next;
          if (acc_clamp) begin
            overflow_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_energy_accumulator.sv
// Bench for energy_accumulator: a 32-bit and a 20-bit instance share stimulus.
// Expected energies come from a per-beat saturating arithmetic model and constant tables.
// Control timing is checked against fixed cycle counts after each handshake.
module tb_energy_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        pvld = 1'b0;
  logic [63:0] pdat = '0;
  logic [3:0]  mask = '0;
  logic        last = 1'b0;
  logic        eready = 1'b0;

  logic        a_ready, a_step, a_recount, a_valid, a_ovf, a_busy;
  logic [31:0] a_energy;
  logic        b_ready, b_step, b_recount, b_valid, b_ovf, b_busy;
  logic [19:0] b_energy;

  int tests = 0;
  int fails = 0;

  longint acc_a, acc_b;
  bit     ovf_a, ovf_b;

  always #5 clk = ~clk;

  energy_accumulator #(.PARALLELISM(4), .PARTIAL_WIDTH(16), .ENERGY_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
    .partial_valid_i(pvld), .partial_ready_o(a_ready), .partial_i(pdat),
    .lane_mask_i(mask), .last_i(last), .step_en_o(a_step), .recount_o(a_recount),
    .energy_o(a_energy), .energy_valid_o(a_valid), .energy_ready_i(eready),
    .overflow_o(a_ovf), .busy_o(a_busy)
  );

  energy_accumulator #(.PARALLELISM(4), .PARTIAL_WIDTH(16), .ENERGY_WIDTH(20)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
    .partial_valid_i(pvld), .partial_ready_o(b_ready), .partial_i(pdat),
    .lane_mask_i(mask), .last_i(last), .step_en_o(b_step), .recount_o(b_recount),
    .energy_o(b_energy), .energy_valid_o(b_valid), .energy_ready_i(eready),
    .overflow_o(b_ovf), .busy_o(b_busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [15:0] l0, l1, l2, l3;
    l0 = a0[15:0]; l1 = a1[15:0]; l2 = a2[15:0]; l3 = a3[15:0];
    return {l3, l2, l1, l0};
  endfunction

  function automatic longint beat_sum(input logic [63:0] d, input logic [3:0] m);
    longint s = 0;
    logic [15:0] lane;
    for (int k = 0; k < 4; k++) begin
      lane = d[k*16 +: 16];
      if (m[k]) s += longint'($signed(lane));
    end
    return s;
  endfunction

  task automatic model_clear();
    acc_a = 0; acc_b = 0; ovf_a = 0; ovf_b = 0;
  endtask

  task automatic model_beat(input logic [63:0] d, input logic [3:0] m);
    longint s;
    longint hi_a, lo_a, hi_b, lo_b;
    s = beat_sum(d, m);
    hi_a = (longint'(1) << 31) - 1; lo_a = -(longint'(1) << 31);
    hi_b = (longint'(1) << 19) - 1; lo_b = -(longint'(1) << 19);
    acc_a += s;
    if (acc_a > hi_a) begin acc_a = hi_a; ovf_a = 1; end
    if (acc_a < lo_a) begin acc_a = lo_a; ovf_a = 1; end
    acc_b += s;
    if (acc_b > hi_b) begin acc_b = hi_b; ovf_b = 1; end
    if (acc_b < lo_b) begin acc_b = lo_b; ovf_b = 1; end
  endtask

  task automatic start_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check("ready_after_start_a", a_ready, 1);
    check("ready_after_start_b", b_ready, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] m, input bit l, input int gaps);
    int n;
    pvld = 1'b0;
    repeat (gaps) tick();
    pdat = d; mask = m; last = l; pvld = 1'b1;
    #1;
    n = 0;
    while (!a_ready && n < 50) begin
      tick();
      n++;
    end
    check("beat_accepted", a_ready, 1);
    check("step_en_a", a_step, longint'(!l));
    check("step_en_b", b_step, longint'(!l));
    model_beat(d, m);
    tick();
    pvld = 1'b0; last = 1'b0;
  endtask

  task automatic wait_result(input int hold, output int lat);
    lat = 0;
    while (!a_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("result_valid_a", a_valid, 1);
    check("result_valid_b", b_valid, 1);
    for (int i = 0; i < hold; i++) begin
      check("held_energy", longint'($signed(a_energy)), acc_a);
      check("held_valid", a_valid, 1);
      tick();
    end
    check("energy_a", longint'($signed(a_energy)), acc_a);
    check("energy_b", longint'($signed(b_energy)), acc_b);
    check("overflow_a", a_ovf, longint'(ovf_a));
    check("overflow_b", b_ovf, longint'(ovf_b));
  endtask

  task automatic accept(input bit b2b);
    eready = 1'b1;
    start = b2b;
    #1;
    check("recount_a", a_recount, 1);
    check("recount_b", b_recount, 1);
    tick();
    eready = 1'b0;
    start = 1'b0;
    if (b2b) begin
      model_clear();
      check("b2b_busy", a_busy, 1);
      check("b2b_ready", a_ready, 1);
      check("b2b_acc_clear", longint'($signed(a_energy)), 0);
      check("b2b_ovf_clear", b_ovf, 0);
    end else begin
      check("idle_busy_a", a_busy, 0);
      check("idle_busy_b", b_busy, 0);
      check("idle_valid", a_valid, 0);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic [3:0]  m;
    longint      exp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int lat;
    bit started;
    int nb;
    logic [63:0] rd;

    // Reset state
    repeat (3) tick();
    check("rst_energy", a_energy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_ready", a_ready, 0);
    check("rst_step", a_step, 0);
    check("rst_recount", a_recount, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_busy", a_busy, 0);
    rst = 1'b0;
    tick();
    pvld = 1'b1;
    #1;
    check("idle_no_ready", a_ready, 0);
    pvld = 1'b0;
    tick();

    // Basic sweep with exact latency
    start_sweep();
    send_beat(pk(1, 2, 3, 4), 4'hF, 0, 0);
    send_beat(pk(-5, 0, 0, 0), 4'hF, 0, 0);
    send_beat(pk(10, 10, 10, 10), 4'hF, 1, 0);
    check("drain_valid_low", a_valid, 0);
    check("drain_busy", a_busy, 1);
    tick();
    check("valid_at_t2", a_valid, 1);
    check("basic_energy", longint'($signed(a_energy)), 45);
    wait_result(0, lat);
    check("valid_latency", lat, 0);
    accept(0);

    // Table of single-beat sweeps
    tbl[0] = '{pk(100, 200, 300, 400), 4'b0011, 300};
    tbl[1] = '{pk(-1, -1, -1, -1), 4'hF, -4};
    tbl[2] = '{pk(32767, 32767, 32767, 32767), 4'hF, 131068};
    tbl[3] = '{pk(-32768, -32768, -32768, -32768), 4'hF, -131072};
    tbl[4] = '{pk(9, 9, 9, 9), 4'b0000, 0};
    tbl[5] = '{pk(7, -3, 5, 1), 4'b1010, -2};
    for (int i = 0; i < 6; i++) begin
      start_sweep();
      send_beat(tbl[i].d, tbl[i].m, 1, 0);
      wait_result(0, lat);
      check("table_energy", longint'($signed(a_energy)), tbl[i].exp);
      accept(0);
    end

    // Saturation on the 20-bit instance, then overflow cleared by next start
    start_sweep();
    for (int i = 0; i < 5; i++) send_beat(pk(32767, 32767, 32767, 32767), 4'hF, i == 4, 0);
    wait_result(0, lat);
    check("sat_energy_b", longint'($signed(b_energy)), 524287);
    check("sat_ovf_b", b_ovf, 1);
    check("sat_energy_a", longint'($signed(a_energy)), 655340);
    accept(0);
    start_sweep();
    check("sat_ovf_cleared", b_ovf, 0);
    send_beat(pk(0, 0, 0, 0), 4'hF, 1, 0);
    wait_result(0, lat);
    accept(0);

    // Enable low for three cycles mid-sweep
    start_sweep();
    send_beat(pk(11, 22, 33, 44), 4'hF, 0, 0);
    send_beat(pk(-7, 8, -9, 10), 4'hF, 0, 0);
    en = 1'b0;
    pvld = 1'b1; pdat = pk(1000, 1000, 1000, 1000); mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_low_ready", a_ready, 0);
      check("en_low_step", a_step, 0);
      check("en_low_busy", a_busy, 1);
      tick();
    end
    pvld = 1'b0;
    en = 1'b1;
    send_beat(pk(1, 1, 1, 1), 4'hF, 1, 0);
    wait_result(0, lat);
    accept(0);

    // Randomized sweeps with gaps, held results and back-to-back restarts
    started = 0;
    for (int r = 0; r < 12; r++) begin
      if (!started) start_sweep();
      nb = 1 + int'($urandom % 6);
      for (int b = 0; b < nb; b++) begin
        rd = {$urandom(), $urandom()};
        send_beat(rd, 4'($urandom % 16), b == nb - 1, int'($urandom % 3));
      end
      wait_result((r % 3 == 0) ? 10 : 0, lat);
      started = (r % 2 == 0) && (r != 11);
      accept(started);
    end

    // Asynchronous reset in the middle of a sweep
    start_sweep();
    send_beat(pk(5, 5, 5, 5), 4'hF, 0, 0);
    pvld = 1'b1; pdat = pk(5, 5, 5, 5); mask = 4'hF;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_energy", a_energy, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_step", a_step, 0);
    check("midrst_recount", a_recount, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_valid", a_valid, 0);
    check("midrst_ovf", b_ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", a_ready, 0);
    check("post_rst_busy", a_busy, 0);
    pvld = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
